// File: rtl/operand_entry_fsm.sv
// Pushbutton/switch front end: synchronizes and debounces DE2 inputs, walks the user
// through operand A, operand B and opcode entry, then offers the result on a valid/ready port.
module operand_entry_fsm #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic        CLOCK_50,
  input  logic        nRST,
  input  logic [3:0]  KEY,
  input  logic [17:0] SW,
  output logic [31:0] port_a,
  output logic [31:0] port_b,
  output logic [3:0]  op,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [1:0]  entry_st,
  output logic [7:0]  txn_count
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_A     = 2'd0,
    S_B     = 2'd1,
    S_OP    = 2'd2,
    S_ISSUE = 2'd3
  } state_t;

  logic [3:0]             key_meta_q, key_sync_q;
  logic [17:0]            sw_meta_q, sw_sync_q;
  logic [3:0]             deb_q, deb_d;
  logic [3:0]             press_q, press_d;
  logic [CNT_W-1:0]       cnt_q [4];
  logic [CNT_W-1:0]       cnt_d [4];

  state_t                 state_q, state_d;
  logic [31:0]            port_a_q, port_a_d;
  logic [31:0]            port_b_q, port_b_d;
  logic [3:0]             op_q, op_d;
  logic                   req_valid_q, req_valid_d;
  logic [7:0]             txn_count_q, txn_count_d;

  logic [31:0]            operand;
  logic                   enter, back, clr;
  logic                   unused_inputs;

  assign unused_inputs = ^{press_q[2], sw_sync_q[17]};

  // Keys idle high, so synchronizers and debounced levels reset to "released".
  always_ff @(posedge CLOCK_50 or negedge nRST) begin
    if (!nRST) begin
      key_meta_q <= 4'hF;
      key_sync_q <= 4'hF;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      deb_q      <= 4'hF;
      press_q    <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      key_meta_q <= KEY;
      key_sync_q <= key_meta_q;
      sw_meta_q  <= SW;
      sw_sync_q  <= sw_meta_q;
      deb_q      <= deb_d;
      press_q    <= press_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (key_sync_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          deb_d[i] = key_sync_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    press_d = deb_q & ~deb_d;
  end

  assign operand = {{16{sw_sync_q[16]}}, sw_sync_q[15:0]};
  assign enter   = press_q[0];
  assign back    = press_q[1];
  assign clr     = press_q[3];

  // A handshake in S_ISSUE is counted even when a clear lands in the same cycle.
  always_comb begin
    state_d     = state_q;
    port_a_d    = port_a_q;
    port_b_d    = port_b_q;
    op_d        = op_q;
    txn_count_d = txn_count_q;

    if (state_q == S_ISSUE && req_ready) begin
      txn_count_d = txn_count_q + 8'd1;
    end

    if (clr) begin
      state_d  = S_A;
      port_a_d = '0;
      port_b_d = '0;
      op_d     = '0;
    end else begin
      case (state_q)
        S_A: begin
          if (enter) begin
            port_a_d = operand;
            state_d  = S_B;
          end
        end
        S_B: begin
          if (back) begin
            state_d = S_A;
          end else if (enter) begin
            port_b_d = operand;
            state_d  = S_OP;
          end
        end
        S_OP: begin
          if (back) begin
            state_d = S_B;
          end else if (enter) begin
            op_d    = sw_sync_q[3:0];
            state_d = S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (req_ready) state_d = S_A;
        end
        default: state_d = S_A;
      endcase
    end

    req_valid_d = (state_d == S_ISSUE);
  end

  always_ff @(posedge CLOCK_50 or negedge nRST) begin
    if (!nRST) begin
      state_q     <= S_A;
      port_a_q    <= '0;
      port_b_q    <= '0;
      op_q        <= '0;
      req_valid_q <= 1'b0;
      txn_count_q <= '0;
    end else begin
      state_q     <= state_d;
      port_a_q    <= port_a_d;
      port_b_q    <= port_b_d;
      op_q        <= op_d;
      req_valid_q <= req_valid_d;
      txn_count_q <= txn_count_d;
    end
  end

  assign port_a    = port_a_q;
  assign port_b    = port_b_q;
  assign op        = op_q;
  assign req_valid = req_valid_q;
  assign entry_st  = state_q;
  assign txn_count = txn_count_q;

endmodule

// File: tb/tb_operand_entry_fsm.sv
// Directed bench for operand_entry_fsm with a handshake scoreboard (DEBOUNCE_CYCLES=4).
module tb_operand_entry_fsm;

  logic        clk;
  logic        nrst;
  logic [3:0]  key;
  logic [17:0] sw;
  logic        req_ready;
  logic [31:0] port_a, port_b;
  logic [3:0]  op;
  logic        req_valid;
  logic [1:0]  entry_st;
  logic [7:0]  txn_count;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
  } txn_t;

  txn_t exp_q[$];
  int   tests_run;
  int   tests_failed;
  logic [7:0] exp_count;

  operand_entry_fsm #(.DEBOUNCE_CYCLES(4)) dut (
    .CLOCK_50 (clk),
    .nRST     (nrst),
    .KEY      (key),
    .SW       (sw),
    .port_a   (port_a),
    .port_b   (port_b),
    .op       (op),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .entry_st (entry_st),
    .txn_count(txn_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Press and release the keys in mask: state updates on the 7th edge after the fall.
  task automatic applyStimulus(input logic [3:0] mask);
    key = ~mask;
    tick(7);
    key = 4'hF;
    tick(8);
  endtask

  task automatic enterTxn(input logic [17:0] sa, input logic [17:0] sb, input logic [3:0] sop);
    txn_t t;
    sw = sa;
    applyStimulus(4'b0001);
    sw = sb;
    applyStimulus(4'b0001);
    sw = {14'd0, sop};
    t.a  = {{16{sa[16]}}, sa[15:0]};
    t.b  = {{16{sb[16]}}, sb[15:0]};
    t.op = sop;
    exp_q.push_back(t);
    applyStimulus(4'b0001);
  endtask

  // Scoreboard monitor: a handshake is about to complete at the next posedge.
  always @(negedge clk) begin
    if (nrst && req_valid && req_ready) begin
      txn_t t;
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL handshake: got unexpected transfer a=%0h b=%0h op=%0h expected none",
                 port_a, port_b, op);
      end else begin
        t = exp_q.pop_front();
        if ({port_a, port_b, op} !== {t.a, t.b, t.op}) begin
          tests_failed++;
          $display("[TB] FAIL handshake: got a=%0h b=%0h op=%0h expected a=%0h b=%0h op=%0h",
                   port_a, port_b, op, t.a, t.b, t.op);
        end
      end
    end
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    exp_count    = 8'd0;
    nrst      = 1'b0;
    key       = 4'hF;
    sw        = '0;
    req_ready = 1'b0;
    tick(3);
    nrst = 1'b1;

    // Idle after reset release
    for (int i = 0; i < 20; i++) begin
      checkOutput("reset_idle", {port_a, port_b, op, req_valid, entry_st, txn_count}, '0);
      tick(1);
    end

    // Glitch rejection, then press latency
    key[0] = 1'b0;
    tick(3);
    key[0] = 1'b1;
    tick(10);
    checkOutput("glitch_ignored", {port_a, entry_st}, '0);
    sw = 18'h00005;
    key[0] = 1'b0;
    tick(6);
    checkOutput("press_not_early", entry_st, 2'd0);
    tick(1);
    checkOutput("press_latency_st", entry_st, 2'd1);
    checkOutput("port_a_capture", port_a, 32'h0000_0005);
    tick(10);
    checkOutput("hold_single_press", entry_st, 2'd1);
    key[0] = 1'b1;
    tick(8);

    // Complete flow with stalled consumer
    sw = 18'h1FFFE;
    applyStimulus(4'b0001);
    checkOutput("port_b_capture", {entry_st, port_b}, {2'd2, 32'hFFFF_FFFE});
    sw = 18'h00002;
    begin
      txn_t t;
      t.a = 32'h5; t.b = 32'hFFFF_FFFE; t.op = 4'h2;
      exp_q.push_back(t);
    end
    applyStimulus(4'b0001);
    for (int i = 0; i < 10; i++) begin
      checkOutput("stall_stable", {port_a, port_b, op, req_valid, entry_st},
                  {32'h5, 32'hFFFF_FFFE, 4'h2, 1'b1, 2'd3});
      tick(1);
    end
    req_ready = 1'b1;
    tick(1);
    req_ready = 1'b0;
    exp_count = exp_count + 8'd1;
    checkOutput("after_handshake", {txn_count, entry_st, req_valid}, {exp_count, 2'd0, 1'b0});

    // Back navigation and back-over-enter priority
    sw = 18'h00007;
    applyStimulus(4'b0001);
    sw = 18'h00009;
    applyStimulus(4'b0001);
    applyStimulus(4'b0010);
    checkOutput("back_from_op", entry_st, 2'd1);
    applyStimulus(4'b0010);
    checkOutput("back_from_b", {entry_st, port_a}, {2'd0, 32'h7});
    applyStimulus(4'b0001);
    checkOutput("reenter_a", {entry_st, port_a}, {2'd1, 32'h9});
    applyStimulus(4'b0011);
    checkOutput("back_beats_enter", {entry_st, port_a}, {2'd0, 32'h9});

    // Clear coinciding with a handshake
    enterTxn(18'h10003, 18'h00004, 4'hA);
    checkOutput("issue_reached", {entry_st, req_valid}, {2'd3, 1'b1});
    key[3] = 1'b0;
    tick(6);
    checkOutput("clear_not_yet", entry_st, 2'd3);
    req_ready = 1'b1;
    tick(1);
    req_ready = 1'b0;
    key[3] = 1'b1;
    exp_count = exp_count + 8'd1;
    checkOutput("clear_with_handshake", {txn_count, port_a, port_b, op, entry_st, req_valid},
                {exp_count, 32'd0, 32'd0, 4'd0, 2'd0, 1'b0});
    tick(8);

    // 256 transfers wrap the counter back to its current value
    for (int i = 0; i < 256; i++) begin
      enterTxn(18'(i), 18'(i ^ 8'h55), 4'(i));
      req_ready = 1'b1;
      tick(1);
      req_ready = 1'b0;
      exp_count = exp_count + 8'd1;
    end
    checkOutput("txn_wrap", txn_count, exp_count);

    // Async reset in the middle of entry
    sw = 18'h00123;
    applyStimulus(4'b0001);
    checkOutput("mid_b", {entry_st, port_a}, {2'd1, 32'h123});
    nrst = 1'b0;
    #1;
    checkOutput("async_reset", {port_a, port_b, op, req_valid, entry_st, txn_count}, '0);
    tick(2);
    nrst = 1'b1;
    tick(20);
    checkOutput("no_spurious_press", {port_a, entry_st, req_valid, txn_count}, '0);
    checkOutput("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
